keypad_scan: RTL and testbench

Scans a 4x4 matrix hex keypad, debounces presses, and delivers each new key as a one-cycle strobe plus a two-digit history register (most recent and previous key). It is the input-side counterpart to the time-multiplexed dual seven-segment display driver. digit_new and digit_old feed the display's two 4-bit digit inputs directly. One key press yields exactly one key_valid pulse, no matter how long the key is held or how much it bounces.

---
 rtl/keypad_scan.sv | 231 +++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 active-low hex keypad one column at a time. It debounces both
// the press and the release, and reports each accepted key exactly once. The
// two most recent keys are kept as a small history that can drive a
// two-digit display directly.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   rows[3:0]  keypad row sense lines, active-low, asynchronous to clk
//   cols[3:0]  keypad column drives, active-low, exactly one bit low
//   key_valid  one-cycle strobe: a new debounced key was accepted
//   key_code   hex code of the last accepted key
//   digit_new  most recent accepted key
//   digit_old  key accepted before digit_new
//
// Parameters
//   SCAN_DIV         cycles each column is driven before advancing (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept press/release (>= 2)
// -----------------------------------------------------------------------------
module keypad_scan #(
   parameter int SCAN_DIV        = 24000,
   parameter int DEBOUNCE_CYCLES = 480000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_PRESS_DB,
      ST_HELD,
      ST_REL_DB
   } state_t;

   // Registered state
   logic [3:0]         sync1_reg;
   logic [3:0]         rows_s_reg;
   state_t             state_reg,     state_next;
   logic [1:0]         col_reg,       col_next;
   logic [3:0]         cols_reg,      cols_next;
   logic [DWELL_W-1:0] dwell_reg,     dwell_next;
   logic [DB_W-1:0]    db_reg,        db_next;
   logic [1:0]         row_reg,       row_next;
   logic               key_valid_reg, key_valid_next;
   logic [3:0]         key_code_reg,  key_code_next;
   logic [3:0]         digit_new_reg, digit_new_next;
   logic [3:0]         digit_old_reg, digit_old_next;

   // Decoded helpers
   logic [2:0]         low_count;
   logic [1:0]         low_row;
   logic [3:0]         latched_pat;
   logic               pat_match;
   logic               row_released;
   logic [3:0]         key_hex;

   // Hex value printed on the key at (row, col).
   function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Column drive and the expected row pattern of the latched key are both
   // one-hot-low decodes of a 2-bit index.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_decode
         assign cols_next[gi]   = (col_next != 2'(gi));
         assign latched_pat[gi] = (row_reg  != 2'(gi));
      end
   endgenerate

   // Count how many rows are pulled low and remember which one (the index is
   // only meaningful when exactly one row is low).
   always_comb begin
      low_count = '0;
      low_row   = '0;
      for (int i = 0; i < 4; i++) begin
         if (!rows_s_reg[i]) begin
            low_count = low_count + 3'd1;
            low_row   = 2'(i);
         end
      end
   end

   assign pat_match    = (rows_s_reg == latched_pat);
   assign row_released = rows_s_reg[row_reg];
   assign key_hex      = code_of(row_reg, col_reg);

   always_comb begin
      state_next     = state_reg;
      col_next       = col_reg;
      dwell_next     = dwell_reg;
      db_next        = db_reg;
      row_next       = row_reg;
      key_valid_next = 1'b0;
      key_code_next  = key_code_reg;
      digit_new_next = digit_new_reg;
      digit_old_next = digit_old_reg;

      unique case (state_reg)
         ST_SCAN: begin
            if (dwell_reg == DWELL_LAST) begin
               dwell_next = '0;
               if (low_count == 3'd1) begin
                  // Exactly one row low on this column: candidate key.
                  row_next   = low_row;
                  db_next    = '0;
                  state_next = ST_PRESS_DB;
               end else begin
                  col_next = col_reg + 2'd1;
               end
            end else begin
               dwell_next = dwell_reg + DWELL_ONE;
            end
         end

         ST_PRESS_DB: begin
            if (!pat_match) begin
               // Any bounce restarts acquisition on the same column.
               dwell_next = '0;
               state_next = ST_SCAN;
            end else if (db_reg == DB_LAST) begin
               state_next     = ST_HELD;
               key_valid_next = 1'b1;
               key_code_next  = key_hex;
               digit_old_next = digit_new_reg;
               digit_new_next = key_hex;
            end else begin
               db_next = db_reg + DB_ONE;
            end
         end

         ST_HELD: begin
            // Only the latched row matters; other keys are ignored.
            if (row_released) begin
               db_next    = '0;
               state_next = ST_REL_DB;
            end
         end

         ST_REL_DB: begin
            if (!row_released) begin
               state_next = ST_HELD;
            end else if (db_reg == DB_LAST) begin
               col_next   = col_reg + 2'd1;
               dwell_next = '0;
               state_next = ST_SCAN;
            end else begin
               db_next = db_reg + DB_ONE;
            end
         end

         default: begin
            state_next = ST_SCAN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg     <= 4'b1111;
         rows_s_reg    <= 4'b1111;
         state_reg     <= ST_SCAN;
         col_reg       <= 2'd0;
         cols_reg      <= 4'b1110;
         dwell_reg     <= '0;
         db_reg        <= '0;
         row_reg       <= 2'd0;
         key_valid_reg <= 1'b0;
         key_code_reg  <= 4'h0;
         digit_new_reg <= 4'h0;
         digit_old_reg <= 4'h0;
      end else begin
         sync1_reg     <= rows;
         rows_s_reg    <= sync1_reg;
         state_reg     <= state_next;
         col_reg       <= col_next;
         cols_reg      <= cols_next;
         dwell_reg     <= dwell_next;
         db_reg        <= db_next;
         row_reg       <= row_next;
         key_valid_reg <= key_valid_next;
         key_code_reg  <= key_code_next;
         digit_new_reg <= digit_new_next;
         digit_old_reg <= digit_old_next;
      end
   end

   assign cols      = cols_reg;
   assign key_valid = key_valid_reg;
   assign key_code  = key_code_reg;
   assign digit_new = digit_new_reg;
   assign digit_old = digit_old_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//
// Drives keypad_scan with a modelled key matrix (rows[r] low iff key (r, c) is
// pressed and column c is driven low). The reference model works at the level
// of key events: every clean press must yield one strobe with the key's hex
// value within a latency window, the two-digit history shifts on each strobe,
// and columns rotate / freeze with timing derived from the scan and debounce
// parameters.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

   localparam int SD  = 4;
   localparam int DEB = 8;

   // Two synchronizer flops plus the dwell sample, then DEB matching cycles.
   localparam int MIN_LAT     = 2 + 1 + DEB;
   localparam int MAX_LAT     = 2 + SD + DEB + 1 + 3 * SD;
   // Cycles from the last low row reading until the column advances again.
   localparam int REL_LAT     = 2 + 1 + DEB;
   localparam int MIN_SPACING = 2 * DEB + 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] rows;
   logic [3:0] cols;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   logic [15:0] press_mask = '0;

   keypad_scan #(
      .SCAN_DIV        (SD),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .key_valid (key_valid),
      .key_code  (key_code),
      .digit_new (digit_new),
      .digit_old (digit_old)
   );

   always #5 clk = ~clk;

   // Keypad matrix model.
   always_comb begin
      rows = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (press_mask[r * 4 + c] && !cols[c]) rows[r] = 1'b0;
         end
      end
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_on_cyc = 0;

   logic [3:0] got_code_q [$];
   int         got_cyc_q  [$];

   logic [3:0] kmap [16];
   logic [3:0] exp_new;
   logic [3:0] exp_old;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Strobe monitor: records every key_valid and checks pulse shape/spacing.
   initial begin
      bit kv_prev   = 1'b0;
      bit have_last = 1'b0;
      int last_kv   = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         check_val("cols_onehot", 32'($countones(~cols)), 32'd1);
         if (kv_prev) check_val("kv_width", 32'(key_valid), 32'd0);
         if (key_valid) begin
            if (have_last) check_val("kv_spacing", 32'((cyc - last_kv) >= MIN_SPACING), 32'd1);
            got_code_q.push_back(key_code);
            got_cyc_q.push_back(cyc);
            $display("strobe: cycle=%0d key_code=%0h digit_new=%0h digit_old=%0h",
                     cyc, key_code, digit_new, digit_old);
            last_kv   = cyc;
            have_last = 1'b1;
         end
         kv_prev = key_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_key(input int idx, input bit on);
      if (on && !press_mask[idx]) last_on_cyc = cyc;
      press_mask[idx] = on;
   endtask

   // Expect exactly one strobe since n0, for key idx, and update the history.
   task automatic expect_strobe(input int n0, input int idx);
      int lat;
      check_val("strobe_count", 32'(got_code_q.size() - n0), 32'd1);
      if (got_code_q.size() > n0) begin
         check_val("strobe_code", 32'(got_code_q[n0]), 32'(kmap[idx]));
         lat = got_cyc_q[n0] - last_on_cyc;
         check_val("latency_min", 32'(lat >= MIN_LAT), 32'd1);
         check_val("latency_max", 32'(lat <= MAX_LAT), 32'd1);
      end
      exp_old = exp_new;
      exp_new = kmap[idx];
      check_val("key_code", 32'(key_code), 32'(exp_new));
      check_val("digit_new", 32'(digit_new), 32'(exp_new));
      check_val("digit_old", 32'(digit_old), 32'(exp_old));
   endtask

   task automatic run_press(input int idx, input int hold, input int gap, input int nb);
      int n0;
      n0 = got_code_q.size();
      for (int b = 0; b < nb; b++) begin
         set_key(idx, 1'b1);
         wait_cycles(int'($urandom_range(1, 3)));
         set_key(idx, 1'b0);
         wait_cycles(int'($urandom_range(1, 3)));
      end
      set_key(idx, 1'b1);
      wait_cycles(hold);
      expect_strobe(n0, idx);
      set_key(idx, 1'b0);
      wait_cycles(gap);
      check_val("no_extra_strobe", 32'(got_code_q.size() - n0), 32'd1);
   endtask

   initial begin
      int         n0;
      int         changes;
      logic [3:0] prev_cols;
      logic [3:0] exp_cols;

      kmap = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'hE, 4'h0, 4'hF, 4'hD};
      exp_new = 4'h0;
      exp_old = 4'h0;

      // Reset and idle rotation.
      reset = 1'b1;
      tick();
      tick();
      check_val("rst_cols", 32'(cols), 32'hE);
      check_val("rst_kv", 32'(key_valid), 32'd0);
      check_val("rst_code", 32'(key_code), 32'd0);
      check_val("rst_new", 32'(digit_new), 32'd0);
      check_val("rst_old", 32'(digit_old), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 17; k++) begin
         exp_cols = 4'b1111;
         exp_cols[(k / SD) % 4] = 1'b0;
         check_val("idle_rotation", 32'(cols), 32'(exp_cols));
         tick();
      end

      // '5' held 40 cycles, then a clean release.
      n0 = got_code_q.size();
      set_key(5, 1'b1);
      wait_cycles(40);
      expect_strobe(n0, 5);
      check_val("held_cols", 32'(cols), 32'hD);
      set_key(5, 1'b0);
      for (int i = 1; i < REL_LAT; i++) begin
         tick();
         check_val("release_frozen", 32'(cols), 32'hD);
      end
      tick();
      check_val("resume_col2", 32'(cols), 32'hB);
      wait_cycles(SD - 1);
      check_val("resume_col2_end", 32'(cols), 32'hB);
      tick();
      check_val("resume_col3", 32'(cols), 32'h7);
      wait_cycles(15);
      check_val("five_one_strobe", 32'(got_code_q.size() - n0), 32'd1);

      // '9' then 'A'.
      run_press(10, 30, 30, 0);
      run_press(3, 30, 30, 0);
      check_val("seq_new", 32'(digit_new), 32'hA);
      check_val("seq_old", 32'(digit_old), 32'h9);

      // Press bounce on 'D': toggles every 3 cycles for 20 cycles, then stays.
      n0 = got_code_q.size();
      for (int i = 0; i < 20; i++) begin
         set_key(15, ((i / 3) % 2) == 0);
         tick();
      end
      set_key(15, 1'b1);
      wait_cycles(30);
      expect_strobe(n0, 15);
      set_key(15, 1'b0);
      wait_cycles(30);
      check_val("d_one_strobe", 32'(got_code_q.size() - n0), 32'd1);

      // Release bounce on '0': one-cycle low glitch at release cycle 4.
      n0 = got_code_q.size();
      set_key(13, 1'b1);
      wait_cycles(30);
      expect_strobe(n0, 13);
      set_key(13, 1'b0);
      wait_cycles(4);
      set_key(13, 1'b1);
      tick();
      set_key(13, 1'b0);
      for (int i = 1; i < REL_LAT; i++) begin
         tick();
         check_val("relbounce_frozen", 32'(cols), 32'hD);
      end
      tick();
      check_val("relbounce_resume", 32'(cols), 32'hB);
      wait_cycles(20);
      check_val("relbounce_no_strobe", 32'(got_code_q.size() - n0), 32'd1);

      // '1' and '4' together share column 0: no strobe, scanning continues.
      n0 = got_code_q.size();
      set_key(0, 1'b1);
      set_key(4, 1'b1);
      changes   = 0;
      prev_cols = cols;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (cols != prev_cols) changes++;
         prev_cols = cols;
      end
      check_val("twokey_rotates", 32'(changes >= 8), 32'd1);
      set_key(0, 1'b0);
      set_key(4, 1'b0);
      wait_cycles(20);
      check_val("twokey_no_strobe", 32'(got_code_q.size() - n0), 32'd0);

      // Reset while 'F' is held.
      n0 = got_code_q.size();
      set_key(14, 1'b1);
      wait_cycles(30);
      expect_strobe(n0, 14);
      reset = 1'b1;
      set_key(14, 1'b0);
      tick();
      check_val("hrst_cols", 32'(cols), 32'hE);
      check_val("hrst_kv", 32'(key_valid), 32'd0);
      check_val("hrst_code", 32'(key_code), 32'd0);
      check_val("hrst_new", 32'(digit_new), 32'd0);
      check_val("hrst_old", 32'(digit_old), 32'd0);
      exp_new = 4'h0;
      exp_old = 4'h0;
      reset   = 1'b0;
      n0 = got_code_q.size();
      wait_cycles(30);
      check_val("hrst_no_strobe", 32'(got_code_q.size() - n0), 32'd0);

      // Randomized presses with optional leading bounce.
      for (int t = 0; t < 12; t++) begin
         run_press(int'($urandom_range(0, 15)), int'($urandom_range(28, 45)),
                   int'($urandom_range(14, 30)), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
